counter_bank: RTL
=================

# counter_bank

Parametrised programmable timer bank for the MIO peripheral space, the successor to the fixed three-channel counter. It provides CHANNELS independent down-counters of WIDTH bits. Each channel is clocked by a tick enable (a `clkdiv` tap) inside the single system clock domain and has a selectable mode: disabled, one-shot, periodic or square-wave. The block raises per-channel outputs and a combined interrupt line for the CPU's INT input.

## Interface
- CHANNELS, 3, number of counter channels (1..16)
- WIDTH, 32, counter/reload width in bits (8..32)
- CH_W, max(1, clog2(CHANNELS)), channel-select width (derived)

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- tick  in  CHANNELS  per-channel prescale inputs; a channel counts on each rising edge of its bit, sampled in clk
- wr_en  in  1  register write strobe, one cycle per write
- wr_sel  in  1  0 = reload register, 1 = control register
- wr_ch  in  CH_W  target channel of the write
- wr_data  in  WIDTH  write data; control uses bits [2:0]
- rd_ch  in  CH_W  channel selected for readback
- rd_data  out  WIDTH  current count of rd_ch, combinational
- counter_OUT  out  CHANNELS  per-channel output, registered
- irq  out  1  OR of all pending flags, registered

## Operation
- Per channel state: count[WIDTH], reload[WIDTH], mode[1:0], ie, running, out, pending, tick_q.
- Control bits: [1:0] mode, where 00 = disabled, 01 = one-shot, 10 = periodic, 11 = square. [2] is ie (interrupt enable).
- Tick event: tick[i] & ~tick_q[i]. tick_q[i] is updated every cycle.
- Reload write: reload <= wr_data, count <= wr_data, running <= 1, out <= 0.
- Control write: mode and ie are updated, pending is cleared, and count <= reload, running <= 1, out <= 0.
- Counting: on a tick event with mode != 00 and running, count decrements.
- Terminal event: a tick event while count == 1. Its effect depends on mode:
  - One-shot: count <= 0, running <= 0, out <= 1 and held until the next write.
  - Periodic: count <= reload, out high for exactly one clk cycle.
  - Square: count <= reload, out toggles.
- Terminal events set pending if ie = 1.
- Reload == 0:
  - One-shot: out <= 1 on the first tick event, no decrement, pending set if ie.
  - Periodic/square: the channel halts with count 0, no events and no pending.
- Disabled mode: count holds, out = 0, no events.
- Address range: writes with wr_ch >= CHANNELS are ignored. rd_data = 0 when rd_ch >= CHANNELS.
- Arithmetic: unsigned, modulo 2^WIDTH. wr_data bits above WIDTH do not exist. Control ignores wr_data[WIDTH-1:3].

## Timing
- Reset values, all channels: count 0, reload 0, mode 00, ie 0, running 0, out 0, pending 0, tick_q 0. Outputs counter_OUT = 0, irq = 0, rd_data = 0.
- Reset is synchronous: it takes effect at the first clk edge with rst_n = 0 and overrides any same-cycle write or tick. A reset mid-count discards all state.
- Count update latency: count changes at the clk edge where tick = 1 and tick_q = 0, and is visible on rd_data right after that edge. A tick held high counts once. A tick toggling every clk cycle counts on alternate cycles.
- Write latency: a write is visible on rd_data in the cycle after the wr_en edge.
- Output latency: counter_OUT and pending update at the same edge as the terminal count update. irq follows one cycle later.
- Write vs. tick collision: a write in the same cycle as a tick event on the same channel wins, and that tick is discarded. Ticks on other channels proceed normally.
- Clear vs. set collision: a control write clears pending and suppresses that cycle's event on that channel. Pending on other channels is unaffected.
- Periodic pulse: counter_OUT[i] is high for one clk cycle only, regardless of tick width.

## Test plan
- Reset and defaults: hold rst_n = 0 for 2 cycles with tick toggling -> all outputs 0; rd_data = 0 for every channel.
- One-shot: ch0 control = 3'b101, reload = 3, 3 tick pulses -> rd_data 3→2→1→0. counter_OUT[0] rises at the third tick and stays high. irq = 1 one cycle later. Ticks after that leave count 0. A control write clears irq.
- Periodic: ch1 control = 3'b110, reload = 2, 6 ticks -> counter_OUT[1] has a 1-cycle pulse at ticks 2, 4, 6. count sequence is 2,1,2,1,2,1,2. irq 0 throughout (ie = 0).
- Square: ch2 control = 3'b011, reload = 1 -> counter_OUT[2] toggles on every tick event; 4 ticks give the pattern 1,0,1,0.
- Collisions: reload write to ch0 in the same cycle as its tick edge -> count = written value, no decrement. Control write on the terminal tick -> no pending, no out pulse.
- Parameters: CHANNELS = 5, WIDTH = 8, reload 8'hFF, periodic, 255 ticks -> pulse on tick 255. rd_ch = 6 -> rd_data = 0. Write with wr_ch = 7 changes nothing.

Source files
------------

// File: rtl/counter_bank.sv
// counter_bank: bank of programmable down-counting timers with
// one-shot, periodic and square-wave modes plus a combined interrupt.
module counter_bank #(
   parameter  int CHANNELS = 3,
   parameter  int WIDTH    = 32,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] tick,
   input  logic                wr_en,
   input  logic                wr_sel,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic [CH_W-1:0]     rd_ch,
   output logic [WIDTH-1:0]    rd_data,
   output logic [CHANNELS-1:0] counter_OUT,
   output logic                irq
);

   typedef enum logic [1:0] {
      M_DIS  = 2'b00,
      M_ONE  = 2'b01,
      M_PER  = 2'b10,
      M_SQR  = 2'b11
   } mode_t;

   logic [WIDTH-1:0]    count  [CHANNELS];
   logic [WIDTH-1:0]    reload [CHANNELS];
   mode_t               mode   [CHANNELS];
   logic [CHANNELS-1:0] ie;
   logic [CHANNELS-1:0] running;
   logic [CHANNELS-1:0] out;
   logic [CHANNELS-1:0] pending;
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] ev;

   // Decode write target; out-of-range channels simply never match
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = wr_en && (int'(wr_ch) == i);
      end
   end

   assign ev = tick & ~tick_q;

   // Per-channel counter, reload, mode and output state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            count[i]  <= '0;
            reload[i] <= '0;
            mode[i]   <= M_DIS;
         end
         ie      <= '0;
         running <= '0;
         out     <= '0;
         pending <= '0;
         tick_q  <= '0;
      end else begin
         tick_q <= tick;
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit[i] && !wr_sel) begin
               reload[i]  <= wr_data;
               count[i]   <= wr_data;
               running[i] <= 1'b1;
               out[i]     <= 1'b0;
            end else if (wr_hit[i]) begin
               mode[i]    <= mode_t'(wr_data[1:0]);
               ie[i]      <= wr_data[2];
               pending[i] <= 1'b0;
               count[i]   <= reload[i];
               running[i] <= 1'b1;
               out[i]     <= 1'b0;
            end else begin
               // periodic pulse lasts a single clk cycle
               if (mode[i] == M_PER || mode[i] == M_DIS) begin
                  out[i] <= 1'b0;
               end
               if (ev[i] && running[i] && mode[i] != M_DIS) begin
                  if (count[i] == '0) begin
                     running[i] <= 1'b0;
                     if (mode[i] == M_ONE) begin
                        out[i] <= 1'b1;
                        if (ie[i]) pending[i] <= 1'b1;
                     end
                  end else if (count[i] == WIDTH'(1)) begin
                     if (ie[i]) pending[i] <= 1'b1;
                     case (mode[i])
                        M_ONE: begin
                           count[i]   <= '0;
                           running[i] <= 1'b0;
                           out[i]     <= 1'b1;
                        end
                        M_PER: begin
                           count[i] <= reload[i];
                           out[i]   <= 1'b1;
                        end
                        M_SQR: begin
                           count[i] <= reload[i];
                           out[i]   <= ~out[i];
                        end
                        default: ;
                     endcase
                  end else begin
                     count[i] <= count[i] - WIDTH'(1);
                  end
               end
            end
         end
      end
   end

   // Interrupt line lags the pending flags by one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) irq <= 1'b0;
      else        irq <= |pending;
   end

   assign counter_OUT = out;

   // Readback mux; unused channel numbers read as zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(rd_ch) == i) rd_data = count[i];
      end
   end

endmodule
